// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed multi-digit seven-segment driver. Latches a
//                packed hex value into a shadow register and scans one digit
//                per SCAN_DIV clocks, with per-digit dp, blanking and optional
//                leading-zero suppression. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);

    localparam logic [IDX_W-1:0]      c_last_idx = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      c_last_cnt = CNT_W'(SCAN_DIV - 1);
    // "Off" levels; XOR-ing an active-high lit pattern with these applies polarity.
    localparam logic [6:0]            c_seg_off  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  c_dp_off   = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] c_an_off   = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                         : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_index;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_dp_req;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic [3:0]              w_nib;
    logic                    w_dp_req;
    logic                    w_blank;
    logic                    w_upper_zero;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    logic                    w_lz_dark;
    logic [6:0]              w_seg_lit;
    logic                    w_dp_lit;
    logic                    w_tc;

    // Hex nibble to active-high {g..a} glyph.
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

    assign w_tc = (r_cnt == c_last_cnt);

    // Select the current digit's shadow fields and test whether it and all higher nibbles are zero.
    always_comb begin
        w_nib        = 4'h0;
        w_dp_req     = 1'b0;
        w_blank      = 1'b0;
        w_upper_zero = 1'b1;
        w_an_sel     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_index == IDX_W'(i)) begin
                w_nib       = r_value[4*i +: 4];
                w_dp_req    = r_dp_req[i];
                w_blank     = r_blank[i];
                w_an_sel[i] = 1'b1;
            end
            if ((IDX_W'(i) >= r_index) && (r_value[4*i +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    // Digit 0 is never suppressed so a zero value still shows "0".
    assign w_lz_dark = lz_suppress && (r_index != '0) && w_upper_zero;
    assign w_seg_lit = (w_blank || w_lz_dark) ? 7'h00 : hex_glyph(w_nib);
    assign w_dp_lit  = w_dp_req && !w_blank;

    // Prescaler and digit index advance only while enabled; frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_index <= '0;
        end else if (enable) begin
            if (w_tc) begin
                r_cnt   <= '0;
                r_index <= (r_index == c_last_idx) ? '0 : r_index + IDX_W'(1);
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Shadow register: captured on load regardless of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value  <= '0;
            r_dp_req <= '0;
            r_blank  <= '0;
        end else if (load) begin
            r_value  <= value;
            r_dp_req <= dp_in;
            r_blank  <= blank_mask;
        end
    end

    // Registered display outputs, dark whenever scanning is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= c_seg_off;
            r_dp         <= c_dp_off;
            r_an         <= c_an_off;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= c_seg_off ^ (enable ? w_seg_lit : 7'h00);
            r_dp         <= c_dp_off ^ (enable && w_dp_lit);
            r_an         <= c_an_off ^ (enable ? w_an_sel : '0);
            r_frame_done <= enable && w_tc && (r_index == c_last_idx);
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
